// File: rtl/acia_rx_fifo.sv
// Receive FIFO for the ACIA: show-ahead circular buffer of received bytes with
// sticky overrun/framing-error flags and a registered level interrupt request.
module acia_rx_fifo #(
  parameter int AW      = 4,
  parameter int IRQ_THR = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_dat,
  input  logic          rx_stb,
  input  logic          rx_err,
  input  logic          rd_stb,
  input  logic          flush,
  input  logic          clr_err,
  output logic [7:0]    rd_dat,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          ovr,
  output logic          ferr,
  output logic          irq
);

  localparam int DEPTH = 2**AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovr_q, ovr_d;
  logic          ferr_q, ferr_d;
  logic          irq_q, irq_d;
  logic          rx_err_q;
  logic          pop_ok, push_ok, ovr_set, ferr_set;

  assign empty  = (count_q == '0);
  assign full   = (count_q == (AW+1)'(DEPTH));
  assign count  = count_q;
  assign ovr    = ovr_q;
  assign ferr   = ferr_q;
  assign irq    = irq_q;
  assign rd_dat = mem[rd_ptr_q];

  always_comb begin
    pop_ok   = rd_stb & ~empty & ~flush;
    // A pop in the same cycle makes room, so a full FIFO still accepts the byte.
    push_ok  = rx_stb & (~full | pop_ok) & ~flush;
    ovr_set  = rx_stb & full & ~pop_ok & ~flush;
    ferr_set = rx_err & ~rx_err_q;

    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end

    ovr_d  = ovr_set  | (ovr_q  & ~clr_err);
    ferr_d = ferr_set | (ferr_q & ~clr_err);
    irq_d  = (count_d >= (AW+1)'(IRQ_THR)) | ovr_d | ferr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      irq_q    <= 1'b0;
      rx_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
      irq_q    <= irq_d;
      rx_err_q <= rx_err;
    end
  end

  // Storage is never reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr_q] <= rx_dat;
  end

endmodule

// File: tb/tb_acia_rx_fifo.sv
// Scoreboard bench for acia_rx_fifo: a queue-based reference model tracks
// expected contents/flags, a negedge monitor compares the DUT against it.
module tb_acia_rx_fifo;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int THR = 1;

  logic clk = 0;
  logic rst = 0, rx_stb = 0, rx_err = 0, rd_stb = 0, flush = 0, clr_err = 0;
  logic [7:0] rx_dat = 0;
  logic [7:0] rd_dat;
  logic empty, full, ovr, ferr, irq;
  logic [AW:0] count;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  // reference model
  byte unsigned q[$];
  bit m_ovr = 0, m_ferr = 0, m_irq = 0, m_prev = 0;

  always #5 clk = ~clk;

  acia_rx_fifo #(.AW(AW), .IRQ_THR(THR)) dut (
    .clk(clk), .rst(rst), .rx_dat(rx_dat), .rx_stb(rx_stb), .rx_err(rx_err),
    .rd_stb(rd_stb), .flush(flush), .clr_err(clr_err), .rd_dat(rd_dat),
    .empty(empty), .full(full), .count(count), .ovr(ovr), .ferr(ferr), .irq(irq)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_edge();
    bit ovr_set, rise;
    int sz;
    ovr_set = 0;
    if (rst) begin
      q.delete(); m_ovr = 0; m_ferr = 0; m_irq = 0; m_prev = 0;
      return;
    end
    sz = q.size();
    if (flush) q.delete();
    else begin
      if (rx_stb && sz == DEPTH && !(rd_stb && sz > 0)) ovr_set = 1;
      if (rd_stb && sz > 0) void'(q.pop_front());
      if (rx_stb && !ovr_set) q.push_back(rx_dat);
    end
    rise = rx_err && !m_prev;
    m_prev = rx_err;
    m_ovr  = ovr_set | (m_ovr  & !clr_err);
    m_ferr = rise    | (m_ferr & !clr_err);
    m_irq  = (q.size() >= THR) | m_ovr | m_ferr;
  endfunction

  // One clock: inputs already set; model follows the edge; strobes drop after.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    rst = 0; rx_stb = 0; rd_stb = 0; flush = 0; clr_err = 0;
  endtask

  task automatic push(input byte unsigned d);
    rx_stb = 1; rx_dat = d; tick();
  endtask

  task automatic pop();
    rd_stb = 1; tick();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", int'(count), q.size());
      chk("empty", int'(empty), int'(q.size() == 0));
      chk("full",  int'(full),  int'(q.size() == DEPTH));
      chk("ovr",   int'(ovr),   int'(m_ovr));
      chk("ferr",  int'(ferr),  int'(m_ferr));
      chk("irq",   int'(irq),   int'(m_irq));
      if (q.size() > 0) chk("rd_dat", int'(rd_dat), int'(q[0]));
    end
  end

  initial begin
    rst = 1; tick();
    rst = 1; tick();
    mon_en = 1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_irq", int'(irq), 0);

    // T1: spaced pushes, then pops
    push(8'h41); tick(); push(8'h42); tick(); push(8'h43); tick();
    chk("t1_count", int'(count), 3);
    chk("t1_head", int'(rd_dat), 8'h41);
    pop(); chk("t1_pop1", int'(rd_dat), 8'h42);
    pop(); chk("t1_pop2", int'(rd_dat), 8'h43);
    pop();
    chk("t1_empty", int'(empty), 1);
    chk("t1_irq", int'(irq), 0);

    // T2: fill then overrun
    for (int i = 0; i < 16; i++) push(byte'(i));
    chk("t2_full", int'(full), 1);
    push(8'hAA);
    chk("t2_ovr", int'(ovr), 1);
    chk("t2_irq", int'(irq), 1);
    for (int i = 0; i < 16; i++) begin
      chk("t2_drain", int'(rd_dat), i);
      pop();
    end
    chk("t2_empty", int'(empty), 1);
    clr_err = 1; tick();
    chk("t2_clr", int'(ovr), 0);

    // T3: push+pop on full
    for (int i = 0; i < 16; i++) push(byte'(8'h10 + i));
    rx_stb = 1; rx_dat = 8'h55; rd_stb = 1; tick();
    chk("t3_count", int'(count), 16);
    chk("t3_ovr", int'(ovr), 0);
    for (int i = 0; i < 15; i++) pop();
    chk("t3_last", int'(rd_dat), 8'h55);
    pop();

    // T4: pop on empty, then push+pop on empty
    pop();
    chk("t4_count0", int'(count), 0);
    rx_stb = 1; rx_dat = 8'h77; rd_stb = 1; tick();
    chk("t4_count1", int'(count), 1);
    chk("t4_dat", int'(rd_dat), 8'h77);
    pop();

    // T5: framing error flag
    rx_err = 1; tick();
    chk("t5_ferr", int'(ferr), 1);
    chk("t5_irq", int'(irq), 1);
    clr_err = 1; tick();
    chk("t5_clr", int'(ferr), 0);
    tick(); tick();
    chk("t5_hold", int'(ferr), 0);
    rx_err = 0; tick();
    rx_err = 1; tick();
    chk("t5_rerise", int'(ferr), 1);
    rx_err = 0; clr_err = 1; tick();

    // T6: wrap with interleaved random push/pop pairs
    for (int i = 0; i < 40; i++) begin
      push(byte'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) != 0) pop();
    end
    while (!empty) pop();
    for (int i = 0; i < 5; i++) push(byte'($urandom_range(0, 255)));
    flush = 1; rx_stb = 1; rx_dat = 8'hEE; tick();
    chk("t6_flush", int'(empty), 1);
    chk("t6_flush_ovr", int'(ovr), 0);

    // fully random traffic including errors, clears and flushes
    for (int i = 0; i < 400; i++) begin
      rx_stb  = ($urandom_range(0, 99) < 60);
      rx_dat  = 8'($urandom);
      rd_stb  = ($urandom_range(0, 99) < 40);
      rx_err  = ($urandom_range(0, 99) < 10) ? ~rx_err : rx_err;
      clr_err = ($urandom_range(0, 99) < 5);
      flush   = ($urandom_range(0, 99) < 2);
      tick();
    end

    // reset mid-burst
    rx_err = 0;
    for (int i = 0; i < 6; i++) push(byte'(8'hC0 + i));
    rst = 1; rx_stb = 1; rx_dat = 8'hDD; tick();
    chk("rst_mid_count", int'(count), 0);
    chk("rst_mid_empty", int'(empty), 1);
    chk("rst_mid_full", int'(full), 0);
    chk("rst_mid_ovr", int'(ovr), 0);
    chk("rst_mid_ferr", int'(ferr), 0);
    chk("rst_mid_irq", int'(irq), 0);
    tick();

    @(negedge clk);
    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
